sync_fifo: RTL and testbench

//   Single-clock, first-word-fall-through FIFO used as a storage primitive by

---
 rtl/sync_fifo_pkg.sv | 13 +
 rtl/sync_fifo.sv | 67 ++++++
 tb/tb_sync_fifo.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_pkg.sv
// Width helpers shared by the FIFO family: pointer and occupancy-counter sizing.
package sync_fifo_pkg;

    // Pointers need at least one bit even for the smallest legal depth.
    function automatic int fifo_ptr_bw(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

    function automatic int fifo_cnt_bw(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with active-low status flags.
// Any depth >= 2 is supported; pointers wrap explicitly rather than by overflow.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enq_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    input  logic                  deq_i,
    output logic [DATA_WIDTH-1:0] dout_o,
    output logic                  full_o_n,
    output logic                  empty_o_n
);

    localparam int PTR_BW = fifo_ptr_bw(FIFO_DEPTH);
    localparam int CNT_BW = fifo_cnt_bw(FIFO_DEPTH);

    localparam logic [PTR_BW-1:0] LAST_PTR  = PTR_BW'(FIFO_DEPTH - 1);
    localparam logic [CNT_BW-1:0] FULL_CNT  = CNT_BW'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_BW-1:0]     wr_ptr;
    logic [PTR_BW-1:0]     rd_ptr;
    logic [CNT_BW-1:0]     count;
    logic                  do_enq;
    logic                  do_deq;

    assign full_o_n  = (count != FULL_CNT);
    assign empty_o_n = (count != '0);

    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign do_enq = enq_i & (full_o_n | deq_i);
    assign do_deq = deq_i & empty_o_n;

    assign dout_o = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (do_enq) begin
            mem[wr_ptr] <= din_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_enq) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_BW'(1);
            end
            if (do_deq) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_BW'(1);
            end
            case ({do_enq, do_deq})
                2'b10:   count <= count + CNT_BW'(1);
                2'b01:   count <= count - CNT_BW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Drives a depth-16 and a depth-260 FIFO with shared stimulus and checks each
// against its own queue-based model of the occupancy and ordering rules.
module tb_sync_fifo;

    localparam int DEPTH_A = 16;
    localparam int DEPTH_B = 260;

    logic       clk = 1'b0;
    logic       rst;
    logic       enq;
    logic       deq;
    logic [7:0] din;
    logic [7:0] dout_a, dout_b;
    logic       full_a_n, empty_a_n, full_b_n, empty_b_n;

    logic [7:0] q_a[$];
    logic [7:0] q_b[$];

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    sync_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(DEPTH_A)) dut_a (
        .clk_i(clk), .rst_i(rst), .enq_i(enq), .din_i(din), .deq_i(deq),
        .dout_o(dout_a), .full_o_n(full_a_n), .empty_o_n(empty_a_n)
    );

    sync_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(DEPTH_B)) dut_b (
        .clk_i(clk), .rst_i(rst), .enq_i(enq), .din_i(din), .deq_i(deq),
        .dout_o(dout_b), .full_o_n(full_b_n), .empty_o_n(empty_b_n)
    );

    // One clock with the given strobes; the models apply the acceptance rules
    // to their pre-edge occupancy, then outputs settle 1 time unit later.
    task automatic cycle(input logic e, input logic [7:0] d, input logic dq);
        bit acc_enq, acc_deq;
        rst = 1'b0; enq = e; din = d; deq = dq;
        @(posedge clk);
        acc_deq = dq && (q_a.size() > 0);
        acc_enq = e && ((q_a.size() < DEPTH_A) || dq);
        if (acc_deq) void'(q_a.pop_front());
        if (acc_enq) q_a.push_back(d);
        acc_deq = dq && (q_b.size() > 0);
        acc_enq = e && ((q_b.size() < DEPTH_B) || dq);
        if (acc_deq) void'(q_b.pop_front());
        if (acc_enq) q_b.push_back(d);
        #1;
        enq = 1'b0; deq = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; enq = 1'b0; deq = 1'b0;
        @(posedge clk);
        q_a.delete();
        q_b.delete();
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        cycle(1'b0, 8'h00, 1'b0);
        compared++;
        if (empty_a_n !== 1'b0 || full_a_n !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL reset_flags_a: got empty_n=%b full_n=%b want 0 1", empty_a_n, full_a_n);
        end
        compared++;
        if (empty_b_n !== 1'b0 || full_b_n !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL reset_flags_b: got empty_n=%b full_n=%b want 0 1", empty_b_n, full_b_n);
        end
        cycle(1'b1, 8'h11, 1'b0);
        compared++;
        if (empty_a_n !== 1'b1 || dout_a !== 8'h11) begin
            mismatched++;
            $display("[TB] FAIL first_write_a: got empty_n=%b dout=%h want 1 11", empty_a_n, dout_a);
        end
    endtask

    task automatic test_fill_drain_16();
        do_reset();
        for (int i = 1; i <= 16; i++) cycle(1'b1, 8'(i), 1'b0);
        compared++;
        if (full_a_n !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL full_after_16: got full_n=%b want 0", full_a_n);
        end
        cycle(1'b1, 8'hFF, 1'b0);
        compared++;
        if (full_a_n !== 1'b0 || dout_a !== 8'h01) begin
            mismatched++;
            $display("[TB] FAIL drop_when_full: got full_n=%b dout=%h want 0 01", full_a_n, dout_a);
        end
        for (int i = 1; i <= 16; i++) begin
            compared++;
            if (empty_a_n !== 1'b1 || dout_a !== 8'(i)) begin
                mismatched++;
                $display("[TB] FAIL drain_order_a[%0d]: got empty_n=%b dout=%h want 1 %h", i, empty_a_n, dout_a, 8'(i));
            end
            cycle(1'b0, 8'h00, 1'b1);
        end
        compared++;
        if (empty_a_n !== 1'b0 || full_a_n !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL empty_after_drain_a: got empty_n=%b full_n=%b want 0 1", empty_a_n, full_a_n);
        end
    endtask

    task automatic test_wrap_260();
        int errs;
        do_reset();
        for (int i = 0; i < DEPTH_B; i++) cycle(1'b1, 8'(i * 7 + 3), 1'b0);
        compared++;
        if (full_b_n !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL full_260: got full_n=%b want 0", full_b_n);
        end
        errs = 0;
        for (int i = 0; i < 200; i++) begin
            if (dout_b !== q_b[0]) errs++;
            cycle(1'b0, 8'h00, 1'b1);
        end
        for (int i = 0; i < 150; i++) cycle(1'b1, 8'($urandom), 1'b0);
        while (q_b.size() > 0) begin
            if (empty_b_n !== 1'b1 || dout_b !== q_b[0]) errs++;
            cycle(1'b0, 8'h00, 1'b1);
        end
        compared++;
        if (errs != 0) begin
            mismatched++;
            $display("[TB] FAIL wrap_order_260: got %0d bad reads want 0", errs);
        end
        compared++;
        if (empty_b_n !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL empty_after_wrap_260: got empty_n=%b want 0", empty_b_n);
        end
    endtask

    task automatic test_back_to_back();
        int errs;
        logic [7:0] v;
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'($urandom), 1'b0);
        errs = 0;
        for (int i = 0; i < 12; i++) begin
            v = dout_a;
            cycle(1'b1, 8'($urandom), 1'b1);
            if (q_a.size() != 8 || dout_a !== q_a[0] || v === dout_a && q_a.size() == 0) errs++;
        end
        compared++;
        if (errs != 0 || empty_a_n !== 1'b1 || full_a_n !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL half_full_rw: got %0d bad cycles flags %b%b want 0 11", errs, empty_a_n, full_a_n);
        end
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0);
        cycle(1'b1, 8'hEE, 1'b1);
        compared++;
        if (full_a_n !== 1'b0 || dout_a !== q_a[0] || q_a[DEPTH_A-1] !== 8'hEE) begin
            mismatched++;
            $display("[TB] FAIL full_rw: got full_n=%b dout=%h want 0 %h", full_a_n, dout_a, q_a[0]);
        end
        errs = 0;
        while (q_a.size() > 0) begin
            if (dout_a !== q_a[0]) errs++;
            cycle(1'b0, 8'h00, 1'b1);
        end
        compared++;
        if (errs != 0) begin
            mismatched++;
            $display("[TB] FAIL full_rw_drain: got %0d bad reads want 0", errs);
        end
        do_reset();
        cycle(1'b1, 8'h77, 1'b1);
        compared++;
        if (empty_a_n !== 1'b1 || dout_a !== 8'h77) begin
            mismatched++;
            $display("[TB] FAIL empty_rw: got empty_n=%b dout=%h want 1 77", empty_a_n, dout_a);
        end
        cycle(1'b0, 8'h00, 1'b1);
        compared++;
        if (empty_a_n !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL empty_rw_count: got empty_n=%b want 0", empty_a_n);
        end
    endtask

    task automatic test_deq_empty();
        int errs;
        do_reset();
        errs = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 8'h00, 1'b1);
            if (empty_a_n !== 1'b0 || full_a_n !== 1'b1 || empty_b_n !== 1'b0) errs++;
        end
        compared++;
        if (errs != 0) begin
            mismatched++;
            $display("[TB] FAIL deq_when_empty: got %0d bad cycles want 0", errs);
        end
        cycle(1'b1, 8'hA5, 1'b0);
        compared++;
        if (empty_a_n !== 1'b1 || dout_a !== 8'hA5 || dout_b !== 8'hA5) begin
            mismatched++;
            $display("[TB] FAIL enq_after_idle_deq: got empty_n=%b dout=%h/%h want 1 a5", empty_a_n, dout_a, dout_b);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 7; i++) cycle(1'b1, 8'(8'h50 + i), 1'b0);
        do_reset();
        compared++;
        if (empty_a_n !== 1'b0 || empty_b_n !== 1'b0 || full_a_n !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL mid_reset_flags: got empty_n=%b/%b full_n=%b want 0/0 1", empty_a_n, empty_b_n, full_a_n);
        end
        cycle(1'b1, 8'h3C, 1'b0);
        compared++;
        if (dout_a !== 8'h3C || dout_b !== 8'h3C) begin
            mismatched++;
            $display("[TB] FAIL mid_reset_readback: got %h/%h want 3c", dout_a, dout_b);
        end
    endtask

    task automatic test_random();
        int errs;
        int enq_pct;
        do_reset();
        errs = 0;
        for (int i = 0; i < 1200; i++) begin
            enq_pct = ((i / 100) % 2 == 0) ? 75 : 30;
            cycle(($urandom_range(99) < enq_pct), 8'($urandom), ($urandom_range(99) < 50));
            if (empty_a_n !== (q_a.size() != 0) || full_a_n !== (q_a.size() != DEPTH_A)) errs++;
            if (empty_b_n !== (q_b.size() != 0) || full_b_n !== (q_b.size() != DEPTH_B)) errs++;
            if (q_a.size() != 0 && dout_a !== q_a[0]) errs++;
            if (q_b.size() != 0 && dout_b !== q_b[0]) errs++;
        end
        compared++;
        if (errs != 0) begin
            mismatched++;
            $display("[TB] FAIL random_traffic: got %0d bad observations want 0", errs);
        end
    endtask

    initial begin
        rst = 1'b1; enq = 1'b0; deq = 1'b0; din = 8'h00;
        test_reset();
        test_fill_drain_16();
        test_wrap_260();
        test_back_to_back();
        test_deq_empty();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
